// File: rtl/trees_pkg.sv
// trees_pkg: shared defaults, FSM state type and command opcodes for trees_ctrl.
package trees_pkg;

    localparam int DEF_N_TREES = 128;
    localparam int DEF_N_NODES = 256;
    localparam int DEF_N_FEATURE = 32;

    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_RUN = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_TREES,
        S_LOAD_FEAT,
        S_START,
        S_WAIT_DONE,
        S_RESULT
    } state_e;

endpackage

// File: rtl/trees_ctrl_addr_gen.sv
// trees_ctrl_addr_gen: word counter that splits the load index into tree/node/feature addresses.
// N_TREES and N_NODES are assumed to be powers of two so the index splits by bit slicing.
module trees_ctrl_addr_gen #(
    parameter int N_TREES = 128,
    parameter int N_NODES = 256,
    parameter int N_FEATURE = 32,
    localparam int TW = $clog2(N_TREES),
    localparam int NW = $clog2(N_NODES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          adv_i,
    output logic [TW-1:0] n_tree_o,
    output logic [NW-1:0] n_node_o,
    output logic [31:0]   n_feature_o,
    output logic          last_tree_o,
    output logic          last_feat_o
);

    logic [TW+NW-1:0] cnt_q, cnt_d;

    assign cnt_d = clr_i ? '0 : cnt_q + (TW+NW)'(adv_i);

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end

    assign {n_tree_o, n_node_o} = cnt_q;
    assign n_feature_o = 32'(cnt_q) << 1;
    assign last_tree_o = cnt_q == (TW+NW)'(N_TREES * N_NODES - 1);
    assign last_feat_o = cnt_q == (TW+NW)'(N_FEATURE / 2 - 1);

endmodule

// File: rtl/trees_ctrl.sv
// trees_ctrl: sequences model loads and per-sample inference runs for the trees engine.
// Optional TREES_CTRL_LAT_EN adds res_latency_o (start pulse to captured done, saturating).
module trees_ctrl
    import trees_pkg::*;
#(
    parameter int N_TREES = DEF_N_TREES,
    parameter int N_NODES = DEF_N_NODES,
    parameter int N_FEATURE = DEF_N_FEATURE,
    localparam int TW = $clog2(N_TREES),
    localparam int NW = $clog2(N_NODES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_op_i,
    input  logic [15:0]        cmd_count_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [63:0]        in_data_i,
    output logic               load_trees_o,
    output logic [TW-1:0]      n_tree_o,
    output logic [NW-1:0]      n_node_o,
    output logic [63:0]        tree_nodes_o,
    output logic               load_features_o,
    output logic [31:0]        n_feature_o,
    output logic [63:0]        features2_o,
    output logic               start_o,
    input  logic               done_i,
    input  logic signed [31:0] prediction_i,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic signed [31:0] res_data_o,
`ifdef TREES_CTRL_LAT_EN
    output logic [31:0]        res_latency_o,
`endif
    output logic               busy_o
);

    state_e st_q;
    logic [15:0] rem_q;
    logic acc, last_tree, last_feat;
    logic [TW-1:0] g_tree;
    logic [NW-1:0] g_node;
    logic [31:0] g_feat;

    assign acc = in_valid_i && in_ready_o;
    assign cmd_ready_o = st_q == S_IDLE;
    assign in_ready_o = st_q == S_LOAD_TREES || st_q == S_LOAD_FEAT;
    assign res_valid_o = st_q == S_RESULT;
    assign busy_o = st_q != S_IDLE;

    // Counter is held at zero whenever no load is in progress, so every load starts at word 0.
    trees_ctrl_addr_gen #(
        .N_TREES(N_TREES),
        .N_NODES(N_NODES),
        .N_FEATURE(N_FEATURE)
    ) u_addr (
        .clk(clk),
        .rst(rst),
        .clr_i(!in_ready_o),
        .adv_i(acc),
        .n_tree_o(g_tree),
        .n_node_o(g_node),
        .n_feature_o(g_feat),
        .last_tree_o(last_tree),
        .last_feat_o(last_feat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= S_IDLE;
            rem_q <= '0;
            load_trees_o <= 1'b0;
            load_features_o <= 1'b0;
            start_o <= 1'b0;
            n_tree_o <= '0;
            n_node_o <= '0;
            tree_nodes_o <= '0;
            n_feature_o <= '0;
            features2_o <= '0;
            res_data_o <= '0;
        end else begin
            load_trees_o <= acc && st_q == S_LOAD_TREES;
            load_features_o <= acc && st_q == S_LOAD_FEAT;
            start_o <= st_q == S_START;
            if (acc && st_q == S_LOAD_TREES) begin
                n_tree_o <= g_tree;
                n_node_o <= g_node;
                tree_nodes_o <= in_data_i;
            end
            if (acc && st_q == S_LOAD_FEAT) begin
                n_feature_o <= g_feat;
                features2_o <= in_data_i;
            end
            case (st_q)
                S_IDLE: if (cmd_valid_i) begin
                    rem_q <= cmd_count_i;
                    st_q <= cmd_op_i == OP_LOAD ? S_LOAD_TREES :
                            cmd_count_i != '0 ? S_LOAD_FEAT : S_IDLE;
                end
                S_LOAD_TREES: if (acc && last_tree) st_q <= S_IDLE;
                S_LOAD_FEAT: if (acc && last_feat) st_q <= S_START;
                S_START: st_q <= S_WAIT_DONE;
                S_WAIT_DONE: if (done_i) begin
                    res_data_o <= prediction_i;
                    st_q <= S_RESULT;
                end
                S_RESULT: if (res_ready_i) begin
                    rem_q <= rem_q - 16'd1;
                    st_q <= rem_q == 16'd1 ? S_IDLE : S_LOAD_FEAT;
                end
                default: st_q <= S_IDLE;
            endcase
        end
    end

`ifdef TREES_CTRL_LAT_EN
    logic [31:0] lat_q;

    // lat_q reads 0 in the cycle the start pulse is visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_q <= '0;
            res_latency_o <= '0;
        end else begin
            lat_q <= st_q == S_START ? '0 :
                     st_q == S_WAIT_DONE && lat_q != '1 ? lat_q + 32'd1 : lat_q;
            if (st_q == S_WAIT_DONE && done_i) res_latency_o <= lat_q;
        end
    end
`endif

endmodule

// File: tb/tb_trees_ctrl.sv
// tb_trees_ctrl: directed bench for trees_ctrl with a per-cycle behavioural model and literal checks.
module tb_trees_ctrl;

    localparam int NT = 128;
    localparam int NN = 256;
    localparam int NF = 32;
    localparam int P_IDLE = 0, P_TREE = 1, P_FEAT = 2, P_START = 3, P_WAIT = 4, P_RES = 5;

    logic clk = 1'b0, rst = 1'b1;
    logic cmd_valid = 1'b0, cmd_op = 1'b0, in_valid = 1'b0, res_ready = 1'b0, done = 1'b0;
    logic [15:0] cmd_count = '0;
    logic [63:0] in_data = '0;
    logic [31:0] prediction = '0;
    logic cmd_ready, in_ready, load_trees, load_features, start, res_valid, busy;
    logic [6:0] n_tree;
    logic [7:0] n_node;
    logic [63:0] tree_nodes, features2;
    logic [31:0] n_feature, res_data;
`ifdef TREES_CTRL_LAT_EN
    logic [31:0] res_latency;
`endif

    trees_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op), .cmd_count_i(cmd_count),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .load_trees_o(load_trees), .n_tree_o(n_tree), .n_node_o(n_node), .tree_nodes_o(tree_nodes),
        .load_features_o(load_features), .n_feature_o(n_feature), .features2_o(features2),
        .start_o(start), .done_i(done), .prediction_i(prediction),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
`ifdef TREES_CTRL_LAT_EN
        .res_latency_o(res_latency),
`endif
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int lt_cnt = 0, start_cnt = 0;
    logic [31:0] feat_log[$];
    logic [31:0] res_log[$];
    int pred_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phase plus expected outputs for the next cycle, all at negedge.
    int ph = P_IDLE, k = 0, fi = 0, rem = 0;
    logic e_lt = 0, e_lf = 0, e_st = 0;
    int e_tree = 0, e_node = 0, e_feat = 0;
    logic [63:0] e_tn = '0, e_f2 = '0;
    logic [31:0] e_res = '0, lat = '0, e_lat = '0;

    initial forever begin
        @(negedge clk);
        chk("cmd_ready", cmd_ready, ph == P_IDLE);
        chk("in_ready", in_ready, ph == P_TREE || ph == P_FEAT);
        chk("busy", busy, ph != P_IDLE);
        chk("res_valid", res_valid, ph == P_RES);
        chk("load_trees", load_trees, e_lt);
        chk("load_features", load_features, e_lf);
        chk("start", start, e_st);
        chk("n_tree", n_tree, e_tree);
        chk("n_node", n_node, e_node);
        chk("tree_nodes", tree_nodes, e_tn);
        chk("n_feature", n_feature, e_feat);
        chk("features2", features2, e_f2);
        chk("res_data", res_data, e_res);
`ifdef TREES_CTRL_LAT_EN
        if (ph == P_RES) chk("res_latency", res_latency, e_lat);
`endif
        if (load_trees) begin
            chk("tree_contig", {n_tree, n_node}, lt_cnt);
            lt_cnt++;
        end
        if (load_features) feat_log.push_back(n_feature);
        if (start) start_cnt++;
        if (res_valid && res_ready && !rst) res_log.push_back(res_data);
        if (rst) begin
            ph = P_IDLE; k = 0; fi = 0; rem = 0; lat = '0;
            e_lt = 0; e_lf = 0; e_st = 0; e_tree = 0; e_node = 0; e_feat = 0;
            e_tn = '0; e_f2 = '0; e_res = '0;
        end else begin
            e_lt = 0; e_lf = 0; e_st = 0;
            case (ph)
                P_IDLE: if (cmd_valid) begin
                    if (!cmd_op) begin ph = P_TREE; k = 0; end
                    else if (cmd_count != 0) begin ph = P_FEAT; rem = cmd_count; fi = 0; end
                end
                P_TREE: if (in_valid) begin
                    e_lt = 1; e_tree = k / NN; e_node = k % NN; e_tn = in_data; k++;
                    if (k == NT * NN) ph = P_IDLE;
                end
                P_FEAT: if (in_valid) begin
                    e_lf = 1; e_feat = 2 * fi; e_f2 = in_data; fi++;
                    if (fi == NF / 2) ph = P_START;
                end
                P_START: begin e_st = 1; lat = '0; ph = P_WAIT; end
                P_WAIT: if (done) begin
                    e_res = prediction; e_lat = lat; ph = P_RES;
                end else if (lat != '1) lat++;
                P_RES: if (res_ready) begin
                    rem--; fi = 0; ph = rem > 0 ? P_FEAT : P_IDLE;
                end
                default: ph = P_IDLE;
            endcase
        end
    end

    // Engine stand-in: done one cycle, 40 cycles after each start pulse.
    initial forever begin
        @(negedge clk);
        if (start) begin
            repeat (40) @(posedge clk);
            #1 done = 1'b1;
            prediction = pred_q.size() > 0 ? 32'(pred_q.pop_front()) : 32'd0;
            @(posedge clk);
            #1 done = 1'b0;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cmd(input logic op, input logic [15:0] cnt);
        int n = 0;
        logic a;
        cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt;
        do begin @(negedge clk); a = cmd_ready; @(posedge clk); #1; n++; end while (!a && n < 100);
        cmd_valid = 1'b0;
        chk("cmd_accept", a, 1);
    endtask

    task automatic words(input int n, input bit gaps);
        int m;
        logic a;
        for (int w = 0; w < n; w++) begin
            if (gaps && w < 4096 && $urandom_range(2) == 0) begin
                in_valid = 1'b0; @(posedge clk); #1;
            end
            in_valid = 1'b1; in_data = {$urandom, $urandom}; m = 0;
            do begin @(negedge clk); a = in_ready; @(posedge clk); #1; m++; end while (!a && m < 100);
            if (!a) begin chk("word_accept", a, 1); break; end
        end
        in_valid = 1'b0;
    endtask

    task automatic get_result(input int stall);
        int m = 0;
        logic a;
        res_ready = 1'b0;
        do begin @(negedge clk); a = res_valid; @(posedge clk); #1; m++; end while (!a && m < 200);
        chk("res_wait", a, 1);
        repeat (stall) begin
            chk("in_ready_in_result", in_ready, 0);
            @(posedge clk); #1;
        end
        res_ready = 1'b1; @(posedge clk); #1; res_ready = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_res_data", res_data, 0);
        // Full-rate model load
        lt_cnt = 0;
        cmd(1'b0, 16'd0);
        words(NT * NN, 1'b0);
        settle();
        chk("load_strobes", lt_cnt, 32768);
        chk("load_last_tree", n_tree, 127);
        chk("load_last_node", n_node, 255);
        chk("load_busy_end", busy, 0);
        // Single-sample run
        feat_log.delete(); res_log.delete(); start_cnt = 0;
        pred_q.push_back(-5);
        cmd(1'b1, 16'd1);
        words(NF / 2, 1'b0);
        get_result(0);
        settle();
        chk("run1_feat_words", feat_log.size(), 16);
        for (int i = 0; i < feat_log.size(); i++) chk("run1_n_feature", feat_log[i], 2 * i);
        chk("run1_starts", start_cnt, 1);
        chk("run1_res", res_log.size() > 0 ? res_log[0] : 32'd0, 32'hFFFF_FFFB);
        // Three samples with stalled result consumer
        res_log.delete(); start_cnt = 0;
        pred_q.push_back(11); pred_q.push_back(-22); pred_q.push_back(33);
        cmd(1'b1, 16'd3);
        for (int s = 0; s < 3; s++) begin
            words(NF / 2, 1'b0);
            get_result(10);
        end
        settle();
        chk("run3_count", res_log.size(), 3);
        chk("run3_starts", start_cnt, 3);
        if (res_log.size() == 3) begin
            chk("run3_res0", res_log[0], 32'd11);
            chk("run3_res1", res_log[1], 32'hFFFF_FFEA);
            chk("run3_res2", res_log[2], 32'd33);
        end
        chk("run3_idle", busy, 0);
        // Model load with random input gaps
        lt_cnt = 0;
        cmd(1'b0, 16'd0);
        words(NT * NN, 1'b1);
        settle();
        chk("gap_load_strobes", lt_cnt, 32768);
        chk("gap_last_node", n_node, 255);
        // Reset while word 7 of a feature load is offered
        cmd(1'b1, 16'd2);
        words(7, 1'b0);
        in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0000_0007; rst = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_in_ready", in_ready, 0);
        chk("rst_mid_n_feature", n_feature, 0);
        chk("rst_mid_cmd_ready", cmd_ready, 1);
        feat_log.delete(); res_log.delete();
        pred_q.push_back(-7);
        cmd(1'b1, 16'd1);
        words(NF / 2, 1'b0);
        get_result(2);
        settle();
        chk("restart_first_feat", feat_log.size() > 0 ? feat_log[0] : 32'hFFFF_FFFF, 0);
        chk("restart_feat_words", feat_log.size(), 16);
        // Zero-count run does nothing
        start_cnt = 0;
        cmd(1'b1, 16'd0);
        repeat (60) @(posedge clk);
        #1;
        chk("zero_starts", start_cnt, 0);
        chk("zero_cmd_ready", cmd_ready, 1);
        chk("zero_busy", busy, 0);
`ifdef TREES_CTRL_LAT_EN
        pred_q.push_back(3);
        cmd(1'b1, 16'd1);
        words(NF / 2, 1'b0);
        res_ready = 1'b0;
        repeat (60) begin @(posedge clk); #1; end
        chk("latency40", res_latency, 40);
        get_result(0);
        settle();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trees_ctrl.md
TREES_CTRL -- requirements
Module: trees_ctrl

Interface
REQ-001 Parameter N_TREES, 128, number of trees in the attached trees engine.
REQ-002 Parameter N_NODES, 256, nodes+leaves per tree; N_TREES*N_NODES model words per model load.
REQ-003 Parameter N_FEATURE, 32, 32-bit features per sample; N_FEATURE/2 feature words per sample.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-007 cmd_op  in  1  0 = load model, 1 = run inference.
REQ-008 cmd_count  in  16  number of samples for run; ignored for load.
REQ-009 in_valid/in_ready  in/out  1/1  data stream handshake.
REQ-010 in_data  in  64  model node word, or feature pair {feat[2i+1], feat[2i]}.
REQ-011 load_trees, n_tree, n_node, tree_nodes  out  1, $clog2(N_TREES), $clog2(N_NODES), 64  engine tree write port.
REQ-012 load_features, n_feature, features2  out  1, 32, 64  engine feature write port.
REQ-013 start  out  1  one-cycle engine start pulse.
REQ-014 done, prediction  in  1, 32 signed  engine completion flag and result.
REQ-015 res_valid/res_ready  out/in  1/1  result handshake; res_data  out  32 signed.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 States: IDLE, LOAD_TREES, LOAD_FEAT, START, WAIT_DONE, RESULT.
REQ-018 IDLE: cmd_ready=1; cmd accept with op=0 -> LOAD_TREES; op=1 with count>0 -> LOAD_FEAT; op=1 with count=0 -> stays IDLE.
REQ-019 in_ready=1 only in LOAD_TREES and LOAD_FEAT; cmd_ready=0 outside IDLE.
REQ-020 Engine write ports registered: word k accepted in cycle t -> write strobe with its indices and data in cycle t+1; strobe low in cycles with no accept.
REQ-021 LOAD_TREES: word k drives n_tree=k/N_NODES, n_node=k%N_NODES; after word N_TREES*N_NODES-1 -> IDLE.
REQ-022 LOAD_FEAT: word i (0..N_FEATURE/2-1) drives n_feature=2*i; after last word -> START.
REQ-023 START: start=1 exactly one cycle, issued after final load_features strobe; next state WAIT_DONE.
REQ-024 WAIT_DONE: first cycle with done=1 captures prediction into res_data -> RESULT; done outside WAIT_DONE ignored.
REQ-025 RESULT: res_valid=1, res_data stable until res_ready; on handshake decrement remaining samples; remaining>0 -> LOAD_FEAT, else IDLE.
REQ-026 Stalls (in_valid=0 or res_ready=0) hold all indices; no word skipped or duplicated.

Reset
REQ-027 rst=1 at any time, including mid-load or WAIT_DONE: next cycle state IDLE, counters 0, all strobes, start, res_valid, busy, in_ready low, cmd_ready high after rst deasserts, res_data 0, index outputs 0.

Configuration
REQ-028 Macro TREES_CTRL_LAT_EN defined: extra output res_latency[31:0] = cycles from start pulse to captured done, valid with res_valid, saturating at 2^32-1.
REQ-029 Macro undefined: port and counter absent; all other behaviour identical.

Structure
REQ-030 Package trees_pkg holds N_TREES/N_NODES/N_FEATURE defaults, state enum type, cmd_op encoding constants.
REQ-031 One sub-module trees_ctrl_addr_gen: word counter producing n_tree/n_node/n_feature with stall and clear.

Verification
REQ-032 Load command, 32768 words at full rate -> 32768 load_trees strobes, last with n_tree=127, n_node=255, then busy=0.
REQ-033 Run count=1, 16 words, done asserted 40 cycles after start, prediction=-5 -> n_feature 0,2..30, one start pulse, res_data=-5.
REQ-034 Run count=3 with res_ready low 10 cycles each -> exactly 3 results in order, in_ready=0 during RESULT.
REQ-035 Random in_valid gaps during load -> strobe sequence contiguous, no gap in indices.
REQ-036 rst mid-LOAD_FEAT at word 7 -> IDLE next cycle, new run restarts at n_feature=0.
REQ-037 Run count=0 -> no start pulse, cmd_ready stays 1; with TREES_CTRL_LAT_EN, done 40 cycles after start -> res_latency=40.
